alu_op_issue: RTL

- Instruction-side issue stage that produces the 4-bit ALU control code and 64-bit operands consumed by the 64-bit ALU.
- Decodes a 32-bit RV64 instruction plus register-file read data into {ALUCtrl, A, B}.
- Registers the decoded result and presents it to the execute stage over a valid/ready handshake.
- Contains a 2-entry skid buffer, so execute-side back-pressure never drops or duplicates an operation.

---
 rtl/alu_op_issue.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_issue.sv
// -----------------------------------------------------------------------------
// alu_op_issue
// Issue stage that decodes an RV64 instruction plus register-file read data into
// the {ALUCtrl, A, B} triple consumed by the 64-bit ALU. The decoded operation
// is registered and handed to execute over a valid/ready handshake. A 2-entry
// skid buffer (output register + skid register) absorbs back-pressure so that
// in_ready can be a pure flop with no combinational path from out_ready.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   flush      in   discard all buffered operations (beats accept and drain)
//   in_valid   in   upstream instruction valid
//   in_ready   out  stage can accept an instruction this cycle (registered)
//   instr      in   32-bit instruction word
//   rs1_data   in   register source 1 value
//   rs2_data   in   register source 2 value
//   out_valid  out  A/B/ALUCtrl/illegal valid
//   out_ready  in   execute stage accepts
//   A, B       out  ALU operands
//   ALUCtrl    out  ALU control code
//   illegal    out  presented operation is undecodable
// -----------------------------------------------------------------------------
module alu_op_issue #(
    parameter int unsigned XLEN         = 64,
    parameter logic [3:0]  ILLEGAL_CODE = 4'b1111
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [3:0]      ALUCtrl,
    output logic            illegal
);

    localparam logic [3:0] CtrlAdd = 4'b0010;
    localparam logic [3:0] CtrlSub = 4'b0110;
    localparam logic [3:0] CtrlMul = 4'b0011;
    localparam logic [3:0] CtrlDiv = 4'b0001;
    localparam logic [3:0] CtrlSlt = 4'b0111;
    localparam logic [3:0] CtrlAnd = 4'b0000;

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef struct packed {
        logic [3:0]      ctrl;
        logic            ill;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } op_t;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_e;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    op_t             w_dec;
    logic            w_unused_fields;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign w_imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};

    // Register-index fields are resolved upstream; only the data is used here.
    assign w_unused_fields = ^instr[19:15];

    always_comb begin
        // Default is the illegal encoding; legal cases override it.
        w_dec.ctrl = ILLEGAL_CODE;
        w_dec.ill  = 1'b1;
        w_dec.a    = rs1_data;
        w_dec.b    = rs2_data;
        unique case (w_opcode)
            OpReg: begin
                unique case ({w_funct7, w_funct3})
                    {7'b0000000, 3'b000}: begin w_dec.ctrl = CtrlAdd; w_dec.ill = 1'b0; end
                    {7'b0100000, 3'b000}: begin w_dec.ctrl = CtrlSub; w_dec.ill = 1'b0; end
                    {7'b0000001, 3'b000}: begin w_dec.ctrl = CtrlMul; w_dec.ill = 1'b0; end
                    {7'b0000001, 3'b100}: begin w_dec.ctrl = CtrlDiv; w_dec.ill = 1'b0; end
                    {7'b0000000, 3'b010}: begin w_dec.ctrl = CtrlSlt; w_dec.ill = 1'b0; end
                    {7'b0000000, 3'b111}: begin w_dec.ctrl = CtrlAnd; w_dec.ill = 1'b0; end
                    default: ;
                endcase
            end
            OpImm: begin
                unique case (w_funct3)
                    3'b000: begin
                        w_dec.ctrl = CtrlAdd; w_dec.ill = 1'b0; w_dec.b = w_imm_i;
                    end
                    3'b010: begin
                        w_dec.ctrl = CtrlSlt; w_dec.ill = 1'b0; w_dec.b = w_imm_i;
                    end
                    3'b111: begin
                        w_dec.ctrl = CtrlAnd; w_dec.ill = 1'b0; w_dec.b = w_imm_i;
                    end
                    default: ;
                endcase
            end
            OpLoad: begin
                w_dec.ctrl = CtrlAdd;
                w_dec.ill  = 1'b0;
                w_dec.b    = w_imm_i;
            end
            OpStore: begin
                w_dec.ctrl = CtrlAdd;
                w_dec.ill  = 1'b0;
                w_dec.b    = w_imm_s;
            end
            OpBranch: begin
                if (w_funct3 == 3'b000) begin
                    w_dec.ctrl = CtrlSub;
                    w_dec.ill  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Skid-buffer FSM
    // -------------------------------------------------------------------------
    state_e r_state;
    state_e w_state_next;
    logic   r_in_ready;
    logic   w_accept;
    op_t    r_out;
    op_t    r_skid;

    // in_ready is a flop, so accept needs no knowledge of out_ready.
    assign w_accept = in_valid && r_in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StEmpty;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != StTwo);
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = StEmpty;
        end else begin
            case (r_state)
                StEmpty: if (w_accept) w_state_next = StOne;
                StOne: begin
                    if (w_accept && !out_ready)      w_state_next = StTwo;
                    else if (!w_accept && out_ready) w_state_next = StEmpty;
                end
                StTwo:   if (out_ready) w_state_next = StOne;
                default: w_state_next = StEmpty;
            endcase
        end
    end

    // Datapath registers. Flush only clears state; stale data is harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_skid <= '0;
        end else if (!flush) begin
            case (r_state)
                StEmpty: if (w_accept) r_out <= w_dec;
                StOne: begin
                    if (w_accept) begin
                        if (out_ready) r_out  <= w_dec;
                        else           r_skid <= w_dec;
                    end
                end
                StTwo:   if (out_ready) r_out <= r_skid;
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        out_valid = (r_state != StEmpty);
        in_ready  = r_in_ready;
        A         = r_out.a;
        B         = r_out.b;
        ALUCtrl   = r_out.ctrl;
        illegal   = r_out.ill;
    end

endmodule
